// File: rtl/spi_pkg.sv
// Shared definitions for the SPI byte peripheral.
//   - spi_state_e : FSM states (IDLE waits for select, LOAD primes the TX
//                   shift register, SHIFT moves bits)
//   - DATA_W_DEF / IDLE_FILL_DEF : default word width and idle TX word
//   - CPOL / CPHA : SPI mode constants (mode 0)
package spi_pkg;

  localparam int         DATA_W_DEF    = 8;
  localparam logic [7:0] IDLE_FILL_DEF = 8'hFF;

  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_peripheral_byte_if.sv
// Host-side byte interface of the SPI peripheral.
//   i_TX_Byte / i_TX_DV : word offered for transmission and its write strobe
//   o_TX_Ready          : TX holding buffer empty
//   o_RX_Byte / o_RX_DV : last received word and its one-cycle update pulse
//   o_TX_Underrun       : one-cycle pulse, a word started with no TX data
//
// Handshake: a TX word is transferred on every rising clk edge where
// i_TX_DV=1 and o_TX_Ready=1. i_TX_DV while o_TX_Ready=0 is ignored. There is
// no backpressure on the RX side: o_RX_Byte is valid in the cycle o_RX_DV=1
// and holds until the next complete word.
interface spi_peripheral_byte_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] i_TX_Byte;
  logic              i_TX_DV;
  logic              o_TX_Ready;
  logic [DATA_W-1:0] o_RX_Byte;
  logic              o_RX_DV;
  logic              o_TX_Underrun;

  modport master (
    output i_TX_Byte, i_TX_DV,
    input  o_TX_Ready, o_RX_Byte, o_RX_DV, o_TX_Underrun
  );

  modport slave (
    input  i_TX_Byte, i_TX_DV,
    output o_TX_Ready, o_RX_Byte, o_RX_DV, o_TX_Underrun
  );
endinterface

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser with single-cycle rise/fall strobes.
//   clk   : system clock
//   rst   : asynchronous active-low reset, flops go to RST_VAL
//   din   : asynchronous input
//   level : synchronised level
//   rise  : one-cycle strobe on a synchronised 0->1 transition
//   fall  : one-cycle strobe on a synchronised 1->0 transition
// STAGES must be at least 2.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~prev_q;
  assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_peripheral_byte.sv
// SPI mode-0 peripheral, MSB first, with a one-entry TX holding buffer.
//   clk_in, rst        : system clock, asynchronous active-low reset
//   i_SPI_Clk          : SCLK from the controller (<= clk_in/8)
//   i_SPI_CS_n         : chip select, active-low
//   i_SPI_MOSI         : controller-to-peripheral data
//   o_SPI_MISO         : peripheral-to-controller data (1 when deselected)
//   o_SPI_MISO_En      : MISO pad enable, high while selected
//   bus                : host byte interface (TX buffer write, RX word out)
//   o_dbg_state        : current FSM state
module spi_peripheral_byte
  import spi_pkg::*;
#(
  parameter int               DATA_W      = DATA_W_DEF,
  parameter logic [DATA_W-1:0] IDLE_FILL  = DATA_W'(IDLE_FILL_DEF),
  parameter int               SYNC_STAGES = 2
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  i_SPI_Clk,
  input  logic                  i_SPI_CS_n,
  input  logic                  i_SPI_MOSI,
  output logic                  o_SPI_MISO,
  output logic                  o_SPI_MISO_En,
  spi_peripheral_byte_if.slave  bus,
  output spi_state_e            o_dbg_state
);

  localparam int CNT_W = $clog2(DATA_W);

  // ---------------------------------------------------------------- inputs
  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic cs_level, cs_rise_unused, cs_fall;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
    .clk(clk_in), .rst(rst), .din(i_SPI_Clk),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk_in), .rst(rst), .din(i_SPI_CS_n),
    .level(cs_level), .rise(cs_rise_unused), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk_in), .rst(rst), .din(i_SPI_MOSI),
    .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  // Mode 0: sample on the leading (rising) edge, change on the trailing edge.
  logic sample_stb, change_stb;
  assign sample_stb = (CPHA == 1'b0) ? sclk_rise : sclk_fall;
  assign change_stb = (CPHA == 1'b0) ? sclk_fall : sclk_rise;

  // ---------------------------------------------------------------- state
  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] rx_sr_q;
  logic [DATA_W-1:0] tx_sr_q;
  logic [DATA_W-1:0] buf_q;
  logic              buf_full_q;
  logic [DATA_W-1:0] rx_byte_q;
  logic              rx_dv_q;
  logic              underrun_q;

  logic              last_bit;
  logic              word_done;
  logic              tx_accept;
  logic [DATA_W-1:0] load_word;

  assign last_bit  = (bit_cnt_q == CNT_W'(DATA_W - 1));
  // A deselect arriving with the final edge wins: the word is discarded.
  assign word_done = (state_q == ST_SHIFT) && sample_stb && last_bit && !cs_level;
  assign tx_accept = bus.i_TX_DV && !buf_full_q;
  assign load_word = buf_full_q ? buf_q : IDLE_FILL;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cs_fall) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: if (sample_stb && last_bit) state_d = ST_LOAD;
      default:  state_d = ST_IDLE;
    endcase
    if (cs_level) state_d = ST_IDLE;
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // ------------------------------------------------------------ TX buffer
  // A write and a LOAD cannot both touch the buffer in one cycle: a write
  // needs it empty, and an empty-buffer LOAD sends IDLE_FILL and leaves the
  // freshly written word for the next LOAD.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      buf_q      <= '0;
      buf_full_q <= 1'b0;
    end else if (tx_accept) begin
      buf_q      <= bus.i_TX_Byte;
      buf_full_q <= 1'b1;
    end else if (state_q == ST_LOAD) begin
      buf_full_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) underrun_q <= 1'b0;
    else      underrun_q <= (state_q == ST_LOAD) && !buf_full_q;
  end

  // ----------------------------------------------------- TX shift register
  // The trailing edge that follows the last sample of a word is the one that
  // presents the next word's MSB, which LOAD has already put in place; it is
  // recognised by bit_cnt_q==0 and must not shift.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      tx_sr_q <= '1;
    end else if (state_q == ST_LOAD) begin
      tx_sr_q <= load_word;
    end else if (state_q == ST_SHIFT && change_stb && bit_cnt_q != '0) begin
      tx_sr_q <= {tx_sr_q[DATA_W-2:0], 1'b1};
    end
  end

  // ------------------------------------------------------------- RX side
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      bit_cnt_q <= '0;
      rx_sr_q   <= '0;
    end else if (state_q != ST_SHIFT) begin
      bit_cnt_q <= '0;
    end else if (sample_stb) begin
      rx_sr_q   <= {rx_sr_q[DATA_W-2:0], mosi_level};
      bit_cnt_q <= last_bit ? '0 : bit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      rx_byte_q <= '0;
      rx_dv_q   <= 1'b0;
    end else begin
      rx_dv_q <= word_done;
      if (word_done) rx_byte_q <= {rx_sr_q[DATA_W-2:0], mosi_level};
    end
  end

  // --------------------------------------------------------------- outputs
  // During LOAD the MSB comes straight from the word being loaded so it is
  // on the pin in the same cycle.
  always_comb begin
    o_SPI_MISO = 1'b1;
    case (state_q)
      ST_LOAD:  o_SPI_MISO = load_word[DATA_W-1];
      ST_SHIFT: o_SPI_MISO = tx_sr_q[DATA_W-1];
      default:  o_SPI_MISO = 1'b1;
    endcase
  end

  assign o_SPI_MISO_En     = (state_q != ST_IDLE);
  assign bus.o_TX_Ready    = !buf_full_q;
  assign bus.o_RX_Byte     = rx_byte_q;
  assign bus.o_RX_DV       = rx_dv_q;
  assign bus.o_TX_Underrun = underrun_q;
  assign o_dbg_state       = state_q;

endmodule
